// File: rtl/const_weight_pkg.sv
// rtl/const_weight_pkg.sv - shared types, defaults and helpers for the constant-weight key generator
package const_weight_pkg;

    localparam int CW_WIDTH = 128;
    localparam int CW_IDX_W = $clog2(CW_WIDTH);
    localparam int CW_WT_W  = CW_IDX_W + 1;

    localparam logic [15:0] REJ_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requested weights above the key width cannot be honoured; pin them to the width.
    function automatic int unsigned clamp_weight(input int unsigned weight, input int unsigned limit);
        return (weight > limit) ? limit : weight;
    endfunction

endpackage

// File: rtl/constant_weight_key_gen.sv
// rtl/constant_weight_key_gen.sv - builds a WIDTH-bit key with an exact Hamming weight by rejection sampling
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_weight key request (weight clamped to WIDTH)
//   rnd_valid/rnd_ready/rnd_idx   random bit index stream, consumed only while filling
//   key_valid/key_ready/key_data  finished key, held stable until accepted
//   key_weight                    clamped weight of key_data
//   reject_count                  duplicate indices seen in the current job (saturating)
//   busy                          high whenever a job is in progress or waiting to drain
module constant_weight_key_gen
    import const_weight_pkg::*;
#(
    parameter int WIDTH = CW_WIDTH,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int WT_W  = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WT_W-1:0]  cmd_weight,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [IDX_W-1:0] rnd_idx,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [WIDTH-1:0] key_data,
    output logic [WT_W-1:0]  key_weight,
    output logic [15:0]      reject_count,
    output logic             busy
);

    localparam logic [WT_W-1:0] FULL = WT_W'(WIDTH);
    localparam logic [WT_W-1:0] HALF = WT_W'(WIDTH / 2);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_vec;
    logic [WT_W-1:0]    r_count;
    logic [WT_W-1:0]    r_target;
    logic               r_invert;
    logic [15:0]        r_rej;
    logic [WIDTH-1:0]   r_key_data;
    logic [WT_W-1:0]    r_key_weight;

    logic [WT_W-1:0]    w_weight;
    logic               w_invert;
    logic [WT_W-1:0]    w_target;
    logic               w_cmd_fire;
    logic               w_rnd_fire;
    logic               w_bit_free;
    logic [WIDTH-1:0]   w_one_hot;
    logic [WIDTH-1:0]   w_vec_set;
    logic [WT_W-1:0]    w_count_inc;
    logic               w_fill_last;

    // Heavy keys are built as their sparse complement so the fill never needs
    // more than WIDTH/2 successful draws; exactly WIDTH/2 stays un-inverted.
    assign w_weight    = WT_W'(clamp_weight(int'(cmd_weight), WIDTH));
    assign w_invert    = (w_weight > HALF);
    assign w_target    = w_invert ? (FULL - w_weight) : w_weight;

    assign w_cmd_fire  = cmd_valid && (r_state == IDLE);
    assign w_rnd_fire  = rnd_valid && (r_state == FILL);
    assign w_bit_free  = ~r_vec[rnd_idx];
    assign w_one_hot   = {{(WIDTH-1){1'b0}}, 1'b1} << rnd_idx;
    assign w_vec_set   = r_vec | w_one_hot;
    assign w_count_inc = r_count + 1'b1;
    assign w_fill_last = w_bit_free && (w_count_inc == r_target);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire) begin
                    w_state_next = (w_target == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (w_rnd_fire && w_fill_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE first means a command presented alongside
                // key_ready is only taken on the following cycle.
                if (key_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec        <= '0;
            r_count      <= '0;
            r_target     <= '0;
            r_invert     <= 1'b0;
            r_rej        <= '0;
            r_key_data   <= '0;
            r_key_weight <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_vec        <= '0;
                        r_count      <= '0;
                        r_rej        <= '0;
                        r_target     <= w_target;
                        r_invert     <= w_invert;
                        r_key_weight <= w_weight;
                        // Nothing to draw: the key is all zeros or all ones.
                        if (w_target == '0) begin
                            r_key_data <= {WIDTH{w_invert}};
                        end
                    end
                end
                FILL: begin
                    if (w_rnd_fire) begin
                        if (w_bit_free) begin
                            r_vec   <= w_vec_set;
                            r_count <= w_count_inc;
                            // Key is captured only once complete, so no
                            // partially filled vector ever reaches key_data.
                            if (w_fill_last) begin
                                r_key_data <= r_invert ? ~w_vec_set : w_vec_set;
                            end
                        end else if (r_rej != REJ_MAX) begin
                            r_rej <= r_rej + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready    = (r_state == IDLE);
    assign rnd_ready    = (r_state == FILL);
    assign key_valid    = (r_state == DONE);
    assign busy         = (r_state != IDLE);
    assign key_data     = r_key_data;
    assign key_weight   = r_key_weight;
    assign reject_count = r_rej;

endmodule

// File: tb/tb_constant_weight_key_gen.sv
// tb/tb_constant_weight_key_gen.sv - scoreboard bench for constant_weight_key_gen
module tb_constant_weight_key_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [7:0]   cmd_weight = '0;
    logic         rnd_valid = 1'b0;
    logic         rnd_ready;
    logic [6:0]   rnd_idx = '0;
    logic         key_valid;
    logic         key_ready = 1'b0;
    logic [127:0] key_data;
    logic [7:0]   key_weight;
    logic [15:0]  reject_count;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]   wt;
        bit           has_data;
        logic [127:0] data;
        bit           has_rej;
        logic [15:0]  rej;
    } exp_t;

    exp_t sb[$];

    int rnd_hs  = 0;
    int rnd_rdy = 0;

    constant_weight_key_gen dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_weight   (cmd_weight),
        .rnd_valid    (rnd_valid),
        .rnd_ready    (rnd_ready),
        .rnd_idx      (rnd_idx),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_data     (key_data),
        .key_weight   (key_weight),
        .reject_count (reject_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rnd_valid && rnd_ready) rnd_hs <= rnd_hs + 1;
        if (rnd_ready) rnd_rdy <= rnd_rdy + 1;
    end

    function automatic exp_t mk(input logic [7:0] wt, input bit hd, input logic [127:0] d, input bit hr, input logic [15:0] r);
        exp_t e;
        e.wt = wt; e.has_data = hd; e.data = d; e.has_rej = hr; e.rej = r;
        return e;
    endfunction

    function automatic logic [127:0] bit_at(input int i);
        logic [127:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [7:0] w, input exp_t e);
        int n;
        n = 0;
        cmd_weight = w;
        cmd_valid  = 1'b1;
        while (!cmd_ready && n < 100) begin tick; n++; end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout got cmd_ready=%0b exp 1", cmd_ready);
        end else begin
            tick;
            sb.push_back(e);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [6:0] idx);
        int n;
        n = 0;
        rnd_idx   = idx;
        rnd_valid = 1'b1;
        while (!rnd_ready && n < 100) begin tick; n++; end
        if (!rnd_ready) begin
            checks++; errors++;
            $display("FAIL rnd_accept_timeout got rnd_ready=%0b exp 1", rnd_ready);
        end else begin
            tick;
        end
        rnd_valid = 1'b0;
    endtask

    task automatic release_key;
        key_ready = 1'b1;
        tick;
        key_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL reset_cmd_ready got %0b exp 1", cmd_ready); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (key_valid !== 1'b0)  begin errors++; $display("FAIL reset_key_valid got %0b exp 0", key_valid); end
        checks++; if (rnd_ready !== 1'b0)  begin errors++; $display("FAIL reset_rnd_ready got %0b exp 0", rnd_ready); end
        checks++; if (key_data !== '0)     begin errors++; $display("FAIL reset_key_data got %h exp 0", key_data); end
        checks++; if (key_weight !== 8'd0) begin errors++; $display("FAIL reset_key_weight got %0d exp 0", key_weight); end
        checks++; if (reject_count !== 16'd0) begin errors++; $display("FAIL reset_reject got %0d exp 0", reject_count); end
    endtask

    task automatic test_zero_weight;
        exp_t e;
        int   r0;
        r0 = rnd_rdy;
        do_cmd(8'd0, mk(8'd0, 1, '0, 1, 16'd0));
        e = sb.pop_front();
        checks++; if (key_valid !== 1'b1)  begin errors++; $display("FAIL zero_latency got key_valid=%0b exp 1", key_valid); end
        checks++; if (key_data !== e.data) begin errors++; $display("FAIL zero_data got %h exp %h", key_data, e.data); end
        checks++; if (key_weight !== e.wt) begin errors++; $display("FAIL zero_weight got %0d exp %0d", key_weight, e.wt); end
        checks++; if (rnd_rdy - r0 !== 0)  begin errors++; $display("FAIL zero_rnd_ready got %0d cycles exp 0", rnd_rdy - r0); end
        release_key;
        checks++; if (cmd_ready !== 1'b1 || key_valid !== 1'b0) begin errors++; $display("FAIL zero_release got cmd_ready=%0b key_valid=%0b exp 1/0", cmd_ready, key_valid); end
    endtask

    task automatic test_basic_fill;
        exp_t e;
        do_cmd(8'd3, mk(8'd3, 1, bit_at(0) | bit_at(5) | bit_at(127), 1, 16'd1));
        feed(7'd5);
        feed(7'd5);
        feed(7'd127);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b exp 0", key_valid); end
        feed(7'd0);
        e = sb.pop_front();
        checks++; if (key_valid !== 1'b1)     begin errors++; $display("FAIL basic_latency got key_valid=%0b exp 1", key_valid); end
        checks++; if (key_data !== e.data)    begin errors++; $display("FAIL basic_data got %h exp %h", key_data, e.data); end
        checks++; if (key_weight !== e.wt)    begin errors++; $display("FAIL basic_weight got %0d exp %0d", key_weight, e.wt); end
        checks++; if (reject_count !== e.rej) begin errors++; $display("FAIL basic_reject got %0d exp %0d", reject_count, e.rej); end
        release_key;
    endtask

    task automatic test_invert;
        exp_t e;
        int   h0;
        do_cmd(8'd126, mk(8'd126, 1, ~(bit_at(10) | bit_at(20)), 0, 16'd0));
        feed(7'd10);
        feed(7'd20);
        e = sb.pop_front();
        checks++; if (key_valid !== 1'b1)  begin errors++; $display("FAIL inv_latency got key_valid=%0b exp 1", key_valid); end
        checks++; if (key_data !== e.data) begin errors++; $display("FAIL inv_data got %h exp %h", key_data, e.data); end
        checks++; if (key_weight !== e.wt) begin errors++; $display("FAIL inv_weight got %0d exp %0d", key_weight, e.wt); end
        release_key;
        h0 = rnd_hs;
        do_cmd(8'd200, mk(8'd128, 1, {128{1'b1}}, 0, 16'd0));
        e = sb.pop_front();
        checks++; if (key_valid !== 1'b1)  begin errors++; $display("FAIL clamp_latency got key_valid=%0b exp 1", key_valid); end
        checks++; if (key_data !== e.data) begin errors++; $display("FAIL clamp_data got %h exp %h", key_data, e.data); end
        checks++; if (key_weight !== e.wt) begin errors++; $display("FAIL clamp_weight got %0d exp %0d", key_weight, e.wt); end
        checks++; if (rnd_hs - h0 !== 0)   begin errors++; $display("FAIL clamp_rnd_used got %0d exp 0", rnd_hs - h0); end
        release_key;
    endtask

    task automatic test_random;
        logic [15:0]  lfsr;
        logic [127:0] snap;
        exp_t         e;
        int           w, n, stall;
        bit           hs;
        lfsr = 16'hACE1;
        for (int j = 0; j < 12; j++) begin
            w = (j == 0) ? 64 : (j == 1) ? 65 : (j == 2) ? 128 : $urandom_range(0, 128);
            do_cmd(8'(w), mk(8'(w), 0, '0, 0, 16'd0));
            n = 0;
            while (!key_valid && n < 3000) begin
                rnd_valid = ($urandom_range(0, 3) != 0);
                rnd_idx   = lfsr[6:0];
                hs        = rnd_valid && rnd_ready;
                tick;
                if (hs) lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                n++;
            end
            rnd_valid = 1'b0;
            e = sb.pop_front();
            checks++; if (key_valid !== 1'b1)  begin errors++; $display("FAIL rand_timeout job %0d got key_valid=%0b exp 1", j, key_valid); end
            checks++; if (key_weight !== e.wt) begin errors++; $display("FAIL rand_weight job %0d got %0d exp %0d", j, key_weight, e.wt); end
            checks++; if ($countones(key_data) !== int'(e.wt)) begin errors++; $display("FAIL rand_popcount job %0d got %0d exp %0d", j, $countones(key_data), e.wt); end
            snap  = key_data;
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) begin
                tick;
                checks++; if (key_valid !== 1'b1 || key_data !== snap) begin errors++; $display("FAIL rand_stable job %0d got valid=%0b data=%h exp 1/%h", j, key_valid, key_data, snap); end
            end
            release_key;
        end
    endtask

    task automatic test_reset_abort;
        exp_t e;
        do_cmd(8'd64, mk(8'd64, 0, '0, 0, 16'd0));
        for (int i = 0; i < 40; i++) feed(7'(i));
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %0b exp 1", busy); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        void'(sb.pop_back());
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
        checks++; if (key_valid !== 1'b0)     begin errors++; $display("FAIL abort_key_valid got %0b exp 0", key_valid); end
        checks++; if (reject_count !== 16'd0) begin errors++; $display("FAIL abort_reject got %0d exp 0", reject_count); end
        checks++; if (cmd_ready !== 1'b1)     begin errors++; $display("FAIL abort_cmd_ready got %0b exp 1", cmd_ready); end
        do_cmd(8'd1, mk(8'd1, 1, bit_at(9), 1, 16'd0));
        feed(7'd9);
        e = sb.pop_front();
        checks++; if (key_valid !== 1'b1 || key_data !== e.data) begin errors++; $display("FAIL abort_fresh got valid=%0b data=%h exp 1/%h", key_valid, key_data, e.data); end
        release_key;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        do_cmd(8'd1, mk(8'd1, 1, bit_at(3), 1, 16'd0));
        feed(7'd3);
        e = sb.pop_front();
        checks++; if (key_data !== e.data) begin errors++; $display("FAIL b2b_first got %h exp %h", key_data, e.data); end
        key_ready  = 1'b1;
        cmd_valid  = 1'b1;
        cmd_weight = 8'd0;
        tick;
        key_ready = 1'b0;
        checks++; if (key_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_not_taken got valid=%0b cmd_ready=%0b exp 0/1", key_valid, cmd_ready); end
        tick;
        cmd_valid = 1'b0;
        sb.push_back(mk(8'd0, 1, '0, 1, 16'd0));
        e = sb.pop_front();
        checks++; if (key_valid !== 1'b1 || key_data !== e.data || key_weight !== e.wt) begin errors++; $display("FAIL b2b_taken got valid=%0b data=%h wt=%0d exp 1/%h/%0d", key_valid, key_data, key_weight, e.data, e.wt); end
        release_key;

        do_cmd(8'd2, mk(8'd2, 1, bit_at(0) | bit_at(1), 1, 16'hFFFF));
        feed(7'd0);
        rnd_idx   = 7'd0;
        rnd_valid = 1'b1;
        repeat (70000) tick;
        checks++; if (reject_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reject got %h exp ffff", reject_count); end
        checks++; if (key_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sat_state got valid=%0b busy=%0b exp 0/1", key_valid, busy); end
        rnd_idx = 7'd1;
        tick;
        rnd_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (key_valid !== 1'b1 || key_data !== e.data) begin errors++; $display("FAIL sat_data got valid=%0b data=%h exp 1/%h", key_valid, key_data, e.data); end
        checks++; if (reject_count !== e.rej) begin errors++; $display("FAIL sat_final got %h exp %h", reject_count, e.rej); end
        release_key;
    endtask

    initial begin
        test_reset;
        test_zero_weight;
        test_basic_fill;
        test_invert;
        test_random;
        test_reset_abort;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
